instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage and IF/ID pipeline register for the RISC-V core. It holds the program counter, drives the instruction-memory address, and captures the fetched word with its PC. It sits directly upstream of the decode controller: `id_instr[6:0]` is the opcode the controller decodes. It honours stall requests from the hazard unit, applies taken-branch/jump redirects from EX with a one-slot flush, and halts on a misaligned redirect target.

## Interface
- `PC_W`, default 9: PC width in bits (byte address); PC arithmetic is modulo 2^PC_W.
- `INS_W`, default 32: instruction width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: hold the PC and the IF/ID register.
- `pc_sel` in 1: redirect request (taken branch/JAL, resolved in EX).
- `branch_target` in PC_W: redirect address, valid when `pc_sel`=1.
- `imem_addr` out PC_W: current PC, driven straight from the PC register.
- `imem_rdata` in INS_W: instruction at `imem_addr`, combinational (asynchronous-read memory).
- `id_instr` out INS_W: registered instruction for decode.
- `id_pc` out PC_W: PC of `id_instr`.
- `id_pc_plus4` out PC_W: `id_pc`+4 mod 2^PC_W (JAL link value).
- `id_valid` out 1: `id_instr` is a real fetched instruction, not a bubble.
- `fetch_fault` out 1: sticky misaligned-redirect flag.
- `fetch_count` out 32: count of instructions delivered to ID.

## Operation
- NOP = 32'h0000_0013 (`addi x0,x0,0`). Every bubble loads NOP with `id_valid`=0.
- Two states: RUN and HALT. Reset enters RUN.
- RUN, per edge, first matching case wins:
  1. `pc_sel`=1 and `branch_target[1:0]`≠0: go to HALT, set `fetch_fault`=1, hold PC, load a bubble into IF/ID.
  2. `pc_sel`=1 (aligned target): PC←`branch_target`, load a bubble into IF/ID (squash the wrong-path fetch). This applies even when `stall`=1.
  3. `stall`=1: PC, IF/ID, `fetch_count` all hold.
  4. Otherwise: `id_instr`←`imem_rdata`, `id_pc`←PC, `id_pc_plus4`←PC+4, `id_valid`←1, PC←PC+4, `fetch_count`←`fetch_count`+1.
- HALT: PC frozen, IF/ID holds a bubble, `fetch_count` frozen. `stall` and `pc_sel` are ignored. Only reset exits HALT.
- PC wraps: at PC = 2^PC_W−4, the next PC is 0. `id_pc_plus4` wraps the same way.
- `fetch_count` wraps from 2^32−1 to 0. Bubbles never increment it.
- `imem_addr` equals the PC register at all times, including during stall and HALT.

## Timing
- Reset (asynchronous, immediate) forces: PC=0, `imem_addr`=0, `id_instr`=NOP, `id_pc`=0, `id_pc_plus4`=4, `id_valid`=0, `fetch_fault`=0, `fetch_count`=0, state RUN.
- Reset asserted mid-operation discards any pending redirect or stall on that cycle.
- Latency: the word at address A appears on `id_instr` one edge after PC=A, provided there is no stall or redirect on that edge.
- Redirect penalty:
  - Edge of `pc_sel`: IF/ID becomes a bubble.
  - Next edge: captures the instruction at the target.
  - The instruction already in IF/ID at the redirect edge is overwritten. The controller must already have consumed it in the prior cycle.
- Stall is edge-sampled. A stall of N cycles repeats the same IF/ID contents for N extra cycles.
- `fetch_fault` rises on the edge that enters HALT and stays high until reset.

## Test plan
- Reset release, memory[0..3] = 0x00500093, 0x00A00113, 0x002081B3, 0x0000006F, no stall -> over 4 edges `id_pc` = 0, 4, 8, 12; `id_instr` matches memory; `id_valid`=1 from the first edge; `fetch_count`=4.
- `stall` held 3 cycles while `id_pc`=4 -> `id_pc`=4, `imem_addr`=8, `fetch_count` unchanged for 3 edges; fetch resumes with `id_pc`=8.
- `pc_sel`=1, `branch_target`=0x40 with `stall`=1 on the same cycle -> next edge `id_instr`=NOP, `id_valid`=0, `imem_addr`=0x40; following edge `id_pc`=0x40, `id_valid`=1.
- `pc_sel`=1, `branch_target`=0x42 -> `fetch_fault`=1, `id_valid`=0, PC frozen; later `pc_sel`=1 to 0x80 is ignored; `reset` clears everything to reset values.
- With PC_W=9, run from 0x1F8 -> `id_pc` = 0x1F8, 0x1FC, 0x000; `id_pc_plus4` for 0x1FC = 0x000.
- Assert `reset` asynchronously mid-cycle while `pc_sel`=1 -> outputs reach reset values before the next edge; the redirect is not taken.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address, and registers the
// fetched word together with its PC for decode. Honours stalls, applies
// EX redirects with a one-slot bubble, and halts on a misaligned target.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   stall                hold PC and IF/ID
//   pc_sel/branch_target redirect request and target
//   imem_addr/imem_rdata instruction memory address (PC) and async read data
//   id_instr/id_pc/id_pc_plus4/id_valid  IF/ID register contents
//   fetch_fault          sticky misaligned-redirect flag
//   fetch_count          instructions delivered to ID
module instr_fetch #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned INS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_sel,
    input  logic [PC_W-1:0]  branch_target,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    output logic [INS_W-1:0] id_instr,
    output logic [PC_W-1:0]  id_pc,
    output logic [PC_W-1:0]  id_pc_plus4,
    output logic             id_valid,
    output logic             fetch_fault,
    output logic [31:0]      fetch_count
);

    localparam logic [INS_W-1:0] NOP  = INS_W'(32'h0000_0013);
    localparam logic [PC_W-1:0]  FOUR = PC_W'(4);

    typedef enum logic {RUN, HALT} state_t;

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc, pc_nxt;
    logic [INS_W-1:0]  instr_nxt;
    logic [PC_W-1:0]   id_pc_nxt, id_pc_plus4_nxt;
    logic              valid_nxt, fault_nxt;
    logic [31:0]       count_nxt;

    assign imem_addr = pc;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= '0;
            id_instr    <= NOP;
            id_pc       <= '0;
            id_pc_plus4 <= FOUR;
            id_valid    <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            id_instr    <= instr_nxt;
            id_pc       <= id_pc_nxt;
            id_pc_plus4 <= id_pc_plus4_nxt;
            id_valid    <= valid_nxt;
            fetch_fault <= fault_nxt;
            fetch_count <= count_nxt;
        end
    end

    // Next-state and next-register values; redirect outranks stall
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instr_nxt       = id_instr;
        id_pc_nxt       = id_pc;
        id_pc_plus4_nxt = id_pc_plus4;
        valid_nxt       = id_valid;
        fault_nxt       = fetch_fault;
        count_nxt       = fetch_count;

        case (state)
            RUN: begin
                if (pc_sel && (branch_target[1:0] != 2'b00)) begin
                    state_nxt = HALT;
                    fault_nxt = 1'b1;
                    instr_nxt = NOP;
                    valid_nxt = 1'b0;
                end else if (pc_sel) begin
                    pc_nxt    = branch_target;
                    instr_nxt = NOP;
                    valid_nxt = 1'b0;
                end else if (!stall) begin
                    instr_nxt       = imem_rdata;
                    id_pc_nxt       = pc;
                    id_pc_plus4_nxt = PC_W'(pc + FOUR);
                    valid_nxt       = 1'b1;
                    pc_nxt          = PC_W'(pc + FOUR);
                    count_nxt       = 32'(fetch_count + 32'd1);
                end
            end
            HALT: begin
                instr_nxt = NOP;
                valid_nxt = 1'b0;
            end
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int unsigned PC_W  = 9;
    localparam int unsigned INS_W = 32;
    localparam int unsigned PC_MOD = 512;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             stall = 1'b0;
    logic             pc_sel = 1'b0;
    logic [PC_W-1:0]  branch_target = '0;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_rdata;
    logic [INS_W-1:0] id_instr;
    logic [PC_W-1:0]  id_pc;
    logic [PC_W-1:0]  id_pc_plus4;
    logic             id_valid;
    logic             fetch_fault;
    logic [31:0]      fetch_count;

    logic [31:0] mem [0:127];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[PC_W-1:2]];

    instr_fetch #(.PC_W(PC_W), .INS_W(INS_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel),
        .branch_target(branch_target), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: fetch-stage rules in plain integer arithmetic
    int          m_pc = 0;
    logic [31:0] m_instr = 32'h13;
    int          m_idpc = 0;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;
    logic        m_halt = 1'b0;
    logic [31:0] m_count = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 0; m_instr = 32'h13; m_idpc = 0; m_valid = 1'b0;
            m_fault = 1'b0; m_halt = 1'b0; m_count = 0;
        end else if (m_halt) begin
            m_instr = 32'h13; m_valid = 1'b0;
        end else if (pc_sel && (branch_target % 4 != 0)) begin
            m_halt = 1'b1; m_fault = 1'b1; m_instr = 32'h13; m_valid = 1'b0;
        end else if (pc_sel) begin
            m_pc = int'(branch_target); m_instr = 32'h13; m_valid = 1'b0;
        end else if (!stall) begin
            m_instr = mem[m_pc / 4];
            m_idpc  = m_pc;
            m_valid = 1'b1;
            m_pc    = (m_pc + 4) % PC_MOD;
            m_count = m_count + 1;
        end
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        chk("m_imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("m_id_instr", id_instr, m_instr);
        chk("m_id_pc", 32'(id_pc), 32'(m_idpc));
        chk("m_id_pc_plus4", 32'(id_pc_plus4), 32'((m_idpc + 4) % PC_MOD));
        chk("m_id_valid", 32'(id_valid), 32'(m_valid));
        chk("m_fetch_fault", 32'(fetch_fault), 32'(m_fault));
        chk("m_fetch_count", fetch_count, m_count);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_addr"}, 32'(imem_addr), 32'h0);
        chk({tag, "_instr"}, id_instr, 32'h0000_0013);
        chk({tag, "_pc"}, 32'(id_pc), 32'h0);
        chk({tag, "_pc4"}, 32'(id_pc_plus4), 32'h4);
        chk({tag, "_valid"}, 32'(id_valid), 32'h0);
        chk({tag, "_fault"}, 32'(fetch_fault), 32'h0);
        chk({tag, "_count"}, fetch_count, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0020_81B3;
        mem[3] = 32'h0000_006F;

        @(negedge clk); #1;
        chk_reset_values("rst");
        reset = 1'b0;

        // Straight-line fetch of the first program words
        step(); chk("f0_pc", 32'(id_pc), 32'h0); chk("f0_ins", id_instr, 32'h0050_0093);
        chk("f0_valid", 32'(id_valid), 32'h1);
        step(); chk("f1_pc", 32'(id_pc), 32'h4); chk("f1_ins", id_instr, 32'h00A0_0113);

        // Three-cycle stall holding id_pc=4
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_pc", 32'(id_pc), 32'h4);
            chk("st_addr", 32'(imem_addr), 32'h8);
            chk("st_count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        step(); chk("f2_pc", 32'(id_pc), 32'h8); chk("f2_ins", id_instr, 32'h0020_81B3);
        step(); chk("f3_pc", 32'(id_pc), 32'hC); chk("f3_ins", id_instr, 32'h0000_006F);
        chk("f3_count", fetch_count, 32'd4);

        // Redirect wins over a simultaneous stall
        pc_sel = 1'b1; branch_target = 9'h040; stall = 1'b1;
        step(); chk("rd_ins", id_instr, 32'h0000_0013); chk("rd_valid", 32'(id_valid), 32'h0);
        chk("rd_addr", 32'(imem_addr), 32'h40); chk("rd_count", fetch_count, 32'd4);
        pc_sel = 1'b0; stall = 1'b0;
        step(); chk("rt_pc", 32'(id_pc), 32'h40); chk("rt_valid", 32'(id_valid), 32'h1);
        chk("rt_ins", id_instr, 32'h1000_0010);

        // PC wrap at the top of the 9-bit space
        pc_sel = 1'b1; branch_target = 9'h1F8;
        step(); pc_sel = 1'b0;
        step(); chk("w0_pc", 32'(id_pc), 32'h1F8);
        step(); chk("w1_pc", 32'(id_pc), 32'h1FC); chk("w1_pc4", 32'(id_pc_plus4), 32'h0);
        step(); chk("w2_pc", 32'(id_pc), 32'h0); chk("w2_pc4", 32'(id_pc_plus4), 32'h4);
        chk("w2_count", fetch_count, 32'd8);

        // Misaligned redirect halts; later requests ignored
        pc_sel = 1'b1; branch_target = 9'h042;
        step(); chk("ft_fault", 32'(fetch_fault), 32'h1); chk("ft_valid", 32'(id_valid), 32'h0);
        chk("ft_addr", 32'(imem_addr), 32'h4);
        branch_target = 9'h080;
        step(); chk("hl_addr", 32'(imem_addr), 32'h4); chk("hl_fault", 32'(fetch_fault), 32'h1);
        pc_sel = 1'b0;
        step(); chk("hl_count", fetch_count, 32'd8); chk("hl_ins", id_instr, 32'h0000_0013);

        // Reset clears HALT
        reset = 1'b1; #1;
        chk_reset_values("rst2");
        @(negedge clk); #1; reset = 1'b0;
        step(); chk("rs_pc", 32'(id_pc), 32'h0); chk("rs_valid", 32'(id_valid), 32'h1);
        step(); step(); chk("rs_count", fetch_count, 32'd3);

        // Asynchronous reset mid-cycle while a redirect is pending
        pc_sel = 1'b1; branch_target = 9'h080;
        #2 reset = 1'b1;
        #1 chk_reset_values("arst");
        @(posedge clk); #1;
        chk("arst_hold_addr", 32'(imem_addr), 32'h0);
        @(negedge clk); #1;
        pc_sel = 1'b0; reset = 1'b0;
        step(); chk("ar_pc", 32'(id_pc), 32'h0); chk("ar_addr", 32'(imem_addr), 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
